instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage of the 16-bit multicycle CPU, directly upstream of the opcode decoder. Owns the program counter, issues instruction reads to the shared synchronous memory, holds the fetched word in an instruction register and presents the opcode and operand fields to the decoder. Honours decoder stall, data-access arbitration and branch redirect.

## Interface

- ADDR_W, 16, program-counter and memory address width
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 is forced to 0

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- mem_addr  out  ADDR_W  instruction read address (= pc)
- mem_rd  out  1  instruction read request, one cycle per fetch
- mem_rddata  in  16  read data, valid the cycle after mem_rd=1
- data_access  in  1  decoder/datapath owns memory this cycle (decoder mem_sel); fetch must not issue
- stall  in  1  decoder busy; hold current instruction
- redirect  in  1  branch/jump taken (decoder pc_enable qualified by condition)
- br_target  in  ADDR_W  redirect destination
- instr  out  16  instruction register
- instr_valid  out  1  instr is valid for decode this cycle
- opcode  out  5  instr[4:0]
- rx  out  3  instr[7:5]
- ry  out  3  instr[10:8]
- imm8  out  8  instr[15:8]
- imm11  out  11  instr[15:5]
- pc_cur  out  ADDR_W  address of the instruction in instr
- pc_plus2  out  ADDR_W  pc_cur + 2 (link/fall-through value)

## Operation

- Reset (sync, priority over everything): state=IDLE, pc=RESET_PC, pc_cur=RESET_PC, instr=16'h0000, instr_valid=0, mem_rd=0; field outputs follow instr (all 0).
- FSM states IDLE, FETCH, WAIT, EXEC.
- IDLE: mem_rd=0; next FETCH unconditionally.
- FETCH: mem_addr=pc. If data_access=0: mem_rd=1, next WAIT. If data_access=1: mem_rd=0, stay FETCH (retry every cycle).
- WAIT: mem_rd=0; mem_rddata captured into instr, pc_cur<=pc at end of cycle; next EXEC. data_access ignored (read already issued).
- EXEC: instr_valid=1. If stall=1: hold instr, pc, pc_cur; stay EXEC; redirect ignored. If stall=0: pc <= redirect ? {br_target[ADDR_W-1:1],1'b0} : pc_cur+2; next FETCH.
- instr_valid=0 in IDLE, FETCH, WAIT.
- Arithmetic: pc_plus2 = pc_cur + 2 mod 2^ADDR_W (16'hFFFE -> 16'h0000); pc bit 0 always 0.
- Field outputs are pure slices of instr, combinational from the register.

## Timing

- Unstalled throughput: 3 cycles per instruction (FETCH, WAIT, EXEC); each added data_access cycle in FETCH adds 1; each stall cycle in EXEC adds 1.
- First fetch: reset released at edge 0; IDLE cycle 1, FETCH cycle 2 (mem_rd=1, mem_addr=RESET_PC), WAIT cycle 3, instr_valid=1 cycle 4.
- Redirect is sampled only in EXEC with stall=0; target appears on mem_addr in the next cycle (FETCH). No wrong-path instruction is ever presented.
- Stall and redirect asserted together: stall wins; redirect re-sampled on the first EXEC cycle with stall=0.
- Reset asserted in any state: next cycle is IDLE with reset values; a read issued in the previous FETCH is discarded (mem_rddata not captured).
- Outside EXEC, stall and redirect have no effect.

## Test plan

- Reset then memory {0:16'h0021, 2:16'h0041}: mem_rd at cycle 2 addr 0; cycle 4 instr=16'h0021, opcode=5'b00001, rx=1, pc_cur=0, pc_plus2=2; cycle 7 instr=16'h0041, pc_cur=2.
- data_access=1 for 3 cycles during FETCH at pc=4: mem_rd stays 0 for those 3 cycles, issues on 4th, instr_valid 3 cycles late, instr correct.
- stall=1 for 2 cycles in EXEC (ld): instr_valid held 3 cycles, instr/pc_cur unchanged, no mem_rd; then fetch of pc_cur+2.
- redirect=1, br_target=16'h0103 in EXEC at pc_cur=6: next mem_addr=16'h0102; redirect with stall=1 same cycle ignored, next fetch follows stall release.
- pc_cur=16'hFFFE, no redirect: pc_plus2=16'h0000, next fetch at 16'h0000.
- reset asserted during WAIT: next cycle IDLE, instr=0, instr_valid=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads one 16-bit word per instruction from shared memory, presents it for decode.
// 3 cycles/instr unstalled (FETCH, WAIT, EXEC); data_access delays the read issue, stall holds EXEC.
module instr_fetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rddata,
    input  logic              data_access,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] br_target,
    output logic [15:0]       instr,
    output logic              instr_valid,
    output logic [4:0]        opcode,
    output logic [2:0]        rx,
    output logic [2:0]        ry,
    output logic [7:0]        imm8,
    output logic [10:0]       imm11,
    output logic [ADDR_W-1:0] pc_cur,
    output logic [ADDR_W-1:0] pc_plus2
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXEC
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ALIGN_MASK = ~ADDR_W'(1);
    localparam logic [ADDR_W-1:0] RESET_PC_AL   = RESET_PC & PC_ALIGN_MASK;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_cur;
    logic [15:0]       r_instr;
    logic              r_instr_valid;

    logic              w_issue;
    logic [ADDR_W-1:0] w_pc_plus2;
    logic [ADDR_W-1:0] w_target;

    // The read request must drop in the same cycle the datapath claims memory.
    assign w_issue    = (r_state == S_FETCH) && !data_access;
    assign w_pc_plus2 = r_pc_cur + ADDR_W'(2);
    assign w_target   = br_target & PC_ALIGN_MASK;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC_AL;
            r_pc_cur      <= RESET_PC_AL;
            r_instr       <= 16'h0000;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (w_issue) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_instr       <= mem_rddata;
                    r_pc_cur      <= r_pc;
                    r_instr_valid <= 1'b1;
                    r_state       <= S_EXEC;
                end
                S_EXEC: begin
                    // Stall wins over redirect; redirect is re-sampled once stall drops.
                    if (!stall) begin
                        r_pc          <= redirect ? w_target : w_pc_plus2;
                        r_instr_valid <= 1'b0;
                        r_state       <= S_FETCH;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr    = r_pc;
    assign mem_rd      = w_issue;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign opcode      = r_instr[4:0];
    assign rx          = r_instr[7:5];
    assign ry          = r_instr[10:8];
    assign imm8        = r_instr[15:8];
    assign imm11       = r_instr[15:5];
    assign pc_cur      = r_pc_cur;
    assign pc_plus2    = w_pc_plus2;

endmodule
